// File: rtl/ps2_host_command_transmitter.sv
// ps2_host_command_transmitter
// Sends one command byte from the host to a PS/2 device. The open-drain clock
// and data lines are driven through output enables (1 = pull low). The host
// inhibits the clock and issues the start bit. It then shifts D0..D7, odd
// parity and stop on device clock falling edges. Finally it samples the
// device ACK and waits for the bus to go idle.
//
// Ports
//   i_clk          system clock
//   i_reset        synchronous reset, active low
//   i_tx_req       one-cycle request, i_tx_data captured on the same cycle
//   i_tx_data      command byte
//   o_tx_busy      transfer in flight (state != IDLE)
//   o_tx_done      one-cycle pulse, byte sent and ACK seen
//   o_tx_error     one-cycle pulse, NACK or timeout
//   i_ps2_clk_in   raw PS/2 clock line (asynchronous)
//   i_ps2_data_in  raw PS/2 data line (asynchronous)
//   o_ps2_clk_oe   1 = pull clock low
//   o_ps2_data_oe  1 = pull data low
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | lines released, waiting for a request
// INHIBIT   | clock held low for INHIBIT_CYCLES
// START     | clock released, data pulled low (start bit)
// BITS      | data, parity and stop shifted out on device fe
// ACK       | next fe samples the device ACK
// WAIT_IDLE | wait for clock and data both high
module ps2_host_command_transmitter #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tx_req,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_busy,
  output logic       o_tx_done,
  output logic       o_tx_error,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_data_in,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_BITS, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t             r_state, w_next;
  logic               r_tx_done, r_tx_error;
  logic               w_done_set, w_err_set;
  logic               r_clk_s1, r_clk_s2, r_clk_prev;
  logic               r_data_s1, r_data_s2;
  logic [8:0]         r_shift;
  logic [3:0]         r_bit_cnt;
  logic               r_data_oe_bit;
  logic [INH_W-1:0]   r_inh_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic               w_fe, w_accept, w_inh_end, w_tmo_active, w_tmo_hit;

  assign w_fe         = r_clk_prev & ~r_clk_s2;
  // A request arriving in the same cycle as a DONE/ERROR pulse is dropped so
  // completion and acceptance never coincide.
  assign w_accept     = (r_state == S_IDLE) & i_tx_req & ~r_tx_done & ~r_tx_error;
  assign w_inh_end    = (r_state == S_INHIBIT) & (r_inh_cnt == '0);
  assign w_tmo_active = (r_state == S_START) | (r_state == S_BITS) |
                        (r_state == S_ACK)   | (r_state == S_WAIT_IDLE);
  assign w_tmo_hit    = w_tmo_active & (r_tmo_cnt == '0);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_tx_done  <= 1'b0;
      r_tx_error <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tx_done  <= w_done_set;
      r_tx_error <= w_err_set;
    end
  end

  // Next-state logic; timeout takes priority over any line event
  always_comb begin
    w_next     = r_state;
    w_done_set = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_INHIBIT;
      S_INHIBIT: if (w_inh_end) w_next = S_START;
      S_START: begin
        if (w_tmo_hit) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end else begin
          w_next = S_BITS;
        end
      end
      S_BITS: begin
        if (w_tmo_hit) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end else if (w_fe && (r_bit_cnt == 4'd9)) begin
          w_next = S_ACK;
        end
      end
      S_ACK: begin
        if (w_tmo_hit) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end else if (w_fe) begin
          if (!r_data_s2) begin
            w_next = S_WAIT_IDLE;
          end else begin
            w_next    = S_IDLE;
            w_err_set = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (w_tmo_hit) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end else if (r_clk_s2 && r_data_s2) begin
          w_next     = S_IDLE;
          w_done_set = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_tx_busy     = (r_state != S_IDLE);
    o_tx_done     = r_tx_done;
    o_tx_error    = r_tx_error;
    o_ps2_clk_oe  = (r_state == S_INHIBIT);
    o_ps2_data_oe = (r_state == S_START) | ((r_state == S_BITS) & r_data_oe_bit);
  end

  // Synchronizers, counters and shift register
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_clk_s1      <= 1'b1;
      r_clk_s2      <= 1'b1;
      r_clk_prev    <= 1'b1;
      r_data_s1     <= 1'b1;
      r_data_s2     <= 1'b1;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_data_oe_bit <= 1'b0;
      r_inh_cnt     <= '0;
      r_tmo_cnt     <= '0;
    end else begin
      r_clk_s1   <= i_ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_data_s1  <= i_ps2_data_in;
      r_data_s2  <= r_data_s1;

      if (w_accept) begin
        r_shift   <= {~^i_tx_data, i_tx_data};
        r_inh_cnt <= INH_LOAD;
      end else if ((r_state == S_INHIBIT) && (r_inh_cnt != '0)) begin
        r_inh_cnt <= r_inh_cnt - 1'b1;
      end

      // Entering START: arm the timeout and hold the start bit until the
      // first device falling edge.
      if (w_inh_end) begin
        r_tmo_cnt     <= TMO_LOAD;
        r_bit_cnt     <= '0;
        r_data_oe_bit <= 1'b1;
      end else if (w_tmo_active && (r_tmo_cnt != '0)) begin
        r_tmo_cnt <= r_tmo_cnt - 1'b1;
      end

      if ((r_state == S_BITS) && w_fe) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        if (r_bit_cnt != 4'd9) begin
          r_data_oe_bit <= ~r_shift[0];
          r_shift       <= {1'b0, r_shift[8:1]};
        end else begin
          r_data_oe_bit <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_command_transmitter.sv
module tb_ps2_host_command_transmitter;

  localparam int INH  = 20;
  localparam int TMO  = 1000;
  localparam int HALF = 20;   // device clock half period in CLK cycles

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_tx_req;
  logic [7:0] i_tx_data;
  logic       o_tx_busy, o_tx_done, o_tx_error;
  logic       o_ps2_clk_oe, o_ps2_data_oe;
  logic       dev_clk, dev_data;
  logic       w_ps2_clk, w_ps2_data;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_err    = 0;
  int n_both   = 0;
  int n_busy_at_done = 0;

  assign w_ps2_clk  = dev_clk  & ~o_ps2_clk_oe;
  assign w_ps2_data = dev_data & ~o_ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_command_transmitter #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_tx_req     (i_tx_req),
    .i_tx_data    (i_tx_data),
    .o_tx_busy    (o_tx_busy),
    .o_tx_done    (o_tx_done),
    .o_tx_error   (o_tx_error),
    .i_ps2_clk_in (w_ps2_clk),
    .i_ps2_data_in(w_ps2_data),
    .o_ps2_clk_oe (o_ps2_clk_oe),
    .o_ps2_data_oe(o_ps2_data_oe)
  );

  always @(negedge clk) begin
    if (o_tx_done) n_done++;
    if (o_tx_error) n_err++;
    if (o_tx_done && o_tx_error) n_both++;
    if (o_tx_done && o_tx_busy) n_busy_at_done++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    check_eq("busy_at_req", {31'd0, o_tx_busy}, 32'd0);
    i_tx_req  = 1'b1;
    i_tx_data = d;
    @(negedge clk);
    i_tx_req  = 1'b0;
    check_eq("busy_after_req", {31'd0, o_tx_busy}, 32'd1);
  endtask

  // Device model: waits for the inhibit/release, reads the start bit, then
  // generates n_fe clock pulses, sampling data on each rising edge. The 11th
  // pulse is the ACK pulse, with data held low when ack=1.
  task automatic device_run(input bit ack, input int n_fe,
                            output logic [10:0] bits, output bit ok);
    int n;
    ok   = 1'b1;
    bits = '0;
    n = 0;
    while (!o_ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
    if (!o_ps2_clk_oe) begin ok = 1'b0; return; end
    n = 0;
    while (o_ps2_clk_oe && n < INH + 100) begin @(negedge clk); n++; end
    if (o_ps2_clk_oe) begin ok = 1'b0; return; end
    repeat (10) @(negedge clk);
    bits[0] = w_ps2_data;
    for (int i = 1; i <= n_fe && i <= 11; i++) begin
      if (i == 11) begin
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (4) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) bits[i] = w_ps2_data;
      repeat (HALF) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (o_tx_busy && n < 3000) begin @(negedge clk); n++; end
    check_eq({tag, "_idle"}, {31'd0, o_tx_busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] d, input bit ack,
                          input logic [10:0] exp_bits);
    logic [10:0] bits;
    bit          ok;
    int          d0, e0;
    d0 = n_done;
    e0 = n_err;
    send(d);
    device_run(ack, 11, bits, ok);
    check_eq({tag, "_sync"}, {31'd0, ok}, 32'd1);
    check_eq({tag, "_bits"}, {21'd0, bits}, {21'd0, exp_bits});
    wait_idle(tag);
    check_eq({tag, "_done"}, n_done - d0, ack ? 32'd1 : 32'd0);
    check_eq({tag, "_err"},  n_err - e0,  ack ? 32'd0 : 32'd1);
    check_eq({tag, "_oe"}, {30'd0, o_ps2_clk_oe, o_ps2_data_oe}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] bits;
    bit          ok;
    int          d0, e0, n, m;

    i_reset   = 1'b0;
    i_tx_req  = 1'b0;
    i_tx_data = 8'h00;
    dev_clk   = 1'b1;
    dev_data  = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", {27'd0, o_tx_busy, o_tx_done, o_tx_error,
                            o_ps2_clk_oe, o_ps2_data_oe}, 32'd0);
    i_reset = 1'b1;
    repeat (3) @(negedge clk);

    // bits vector = {stop, parity, D7..D0, start}
    run_xfer("ed", 8'hED, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0});
    run_xfer("x01", 8'h01, 1'b1, {1'b1, 1'b0, 8'h01, 1'b0});
    run_xfer("x00", 8'h00, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0});
    run_xfer("nack", 8'h5A, 1'b0, {1'b1, 1'b1, 8'h5A, 1'b0});

    // Device never clocks: inhibit length, then timeout measured from release
    d0 = n_done;
    e0 = n_err;
    send(8'hA5);
    n = 0;
    while (o_ps2_clk_oe && n < INH + 50) begin n++; @(negedge clk); end
    check_eq("inhibit_len", n, INH);
    m = 0;
    while (!o_tx_error && m < 2 * TMO) begin @(negedge clk); m++; end
    check_eq("tmo_cycles", m, TMO);
    check_eq("tmo_lines", {29'd0, o_ps2_clk_oe, o_ps2_data_oe, o_tx_busy}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("tmo_err", n_err - e0, 32'd1);
    check_eq("tmo_done", n_done - d0, 32'd0);

    // Second request mid-transfer is ignored
    d0 = n_done;
    e0 = n_err;
    send(8'hED);
    fork
      device_run(1'b1, 11, bits, ok);
      begin
        repeat (100) @(negedge clk);
        i_tx_req  = 1'b1;
        i_tx_data = 8'hFF;
        @(negedge clk);
        i_tx_req  = 1'b0;
      end
    join
    check_eq("mid_sync", {31'd0, ok}, 32'd1);
    check_eq("mid_bits", {21'd0, bits}, {21'd0, 1'b1, 1'b1, 8'hED, 1'b0});
    wait_idle("mid");
    repeat (50) @(negedge clk);
    check_eq("mid_no_queue", {31'd0, o_tx_busy}, 32'd0);
    check_eq("mid_done", n_done - d0, 32'd1);
    check_eq("mid_err", n_err - e0, 32'd0);

    // Reset during BITS after four device falling edges
    d0 = n_done;
    e0 = n_err;
    send(8'h3C);
    device_run(1'b1, 4, bits, ok);
    check_eq("rst_sync", {31'd0, ok}, 32'd1);
    check_eq("rst_pre_busy", {31'd0, o_tx_busy}, 32'd1);
    i_reset = 1'b0;
    @(negedge clk);
    check_eq("rst_lines", {29'd0, o_ps2_clk_oe, o_ps2_data_oe, o_tx_busy}, 32'd0);
    i_reset = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst_no_pulse", (n_done - d0) + (n_err - e0), 32'd0);
    run_xfer("f4", 8'hF4, 1'b1, {1'b1, 1'b0, 8'hF4, 1'b0});

    check_eq("done_err_overlap", n_both, 32'd0);
    check_eq("busy_at_done", n_busy_at_done, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
